// File: rtl/turnstile_pkg.sv
// Shared types and defaults for the turnstile input conditioner.
// Holds the coin lockout state encoding and the reject counter width.
package turnstile_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } coin_state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_LOCKOUT_CYCLES  = 32;
    localparam int REJECT_CNT_W        = 8;

    function automatic logic [REJECT_CNT_W-1:0] sat_inc(input logic [REJECT_CNT_W-1:0] v);
        return (&v) ? v : v + REJECT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// One contact channel: synchroniser chain followed by a debounce counter on the stable level.
// Level changes SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first edge that samples a new raw value.
module debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_nxt_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   synced;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
        synced  = sync_q[SYNC_STAGES-1];
        cnt_d   = '0;
        level_d = level_q;
        // Any sample agreeing with the stable level restarts the count.
        if (synced != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                level_d = synced;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // Consumers register this so their pulse lands in the first cycle level_o reads 1.
    assign level_o    = level_q;
    assign rise_nxt_o = level_d & ~level_q;

endmodule

// File: rtl/turnstile_input_cond.sv
// Debounced coin/push event generator feeding the turnstile FSM, with coin lockout and reject count.
// Pulses are registered and coincide with the first cycle of the debounced high level.
module turnstile_input_cond
    import turnstile_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    coin_raw_i,
    input  logic                    push_raw_i,
    output logic                    coin_o,
    output logic                    push_o,
    output logic                    coin_level_o,
    output logic                    push_level_o,
    output logic                    coin_reject_o,
    output logic [REJECT_CNT_W-1:0] reject_count_o
);

    localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);

    logic coin_rise_nxt, push_rise_nxt;

    debounce_sync #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_coin_ds (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .raw_i     (coin_raw_i),
        .level_o   (coin_level_o),
        .rise_nxt_o(coin_rise_nxt)
    );

    debounce_sync #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_push_ds (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .raw_i     (push_raw_i),
        .level_o   (push_level_o),
        .rise_nxt_o(push_rise_nxt)
    );

    coin_state_t             state_q, state_d;
    logic [LK_W-1:0]         lk_q, lk_d;
    logic                    coin_q, coin_d;
    logic                    rej_q, rej_d;
    logic                    push_q, push_d;
    logic [REJECT_CNT_W-1:0] cnt_q, cnt_d;
    logic                    lock_ends;

    always_comb begin
        state_d   = state_q;
        lk_d      = lk_q;
        coin_d    = 1'b0;
        rej_d     = 1'b0;
        cnt_d     = cnt_q;
        push_d    = push_rise_nxt;
        lock_ends = (lk_q <= LK_W'(1));

        if (state_q == LOCKED) begin
            if (lock_ends) begin
                state_d = IDLE;
                lk_d    = '0;
            end else begin
                lk_d = lk_q - LK_W'(1);
            end
        end

        // A rise landing in the cycle the lockout runs out is already free to credit.
        if (coin_rise_nxt) begin
            if (state_q == IDLE || lock_ends) begin
                coin_d  = 1'b1;
                state_d = LOCKED;
                lk_d    = LK_W'(LOCKOUT_CYCLES);
            end else begin
                rej_d = 1'b1;
                cnt_d = sat_inc(cnt_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            lk_q    <= '0;
            coin_q  <= 1'b0;
            rej_q   <= 1'b0;
            push_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lk_q    <= lk_d;
            coin_q  <= coin_d;
            rej_q   <= rej_d;
            push_q  <= push_d;
            cnt_q   <= cnt_d;
        end
    end

    assign coin_o         = coin_q;
    assign push_o         = push_q;
    assign coin_reject_o  = rej_q;
    assign reject_count_o = cnt_q;

endmodule
